// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 receiver that rebuilds shifted-in lines into a ready/valid pixel stream
// through ping-pong line buffers.
module hub75_rx #(
   parameter int WIDTH       = 32,
   parameter int COL_BITS    = 5,
   parameter int ROW_BITS    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          hub_r,
   input  logic [1:0]          hub_g,
   input  logic [1:0]          hub_b,
   input  logic [ROW_BITS-1:0] hub_row,
   input  logic                hub_clk,
   input  logic                hub_lat,
   output logic                px_valid,
   input  logic                px_ready,
   output logic [ROW_BITS-1:0] px_row,
   output logic [COL_BITS-1:0] px_col,
   output logic [5:0]          px_data,
   output logic                px_last,
   output logic                frame_start,
   output logic                err_len,
   output logic                overflow
);
   localparam int IW = 8 + ROW_BITS;
   localparam int CLK_B = ROW_BITS + 6;
   localparam int LAT_B = ROW_BITS + 7;
   localparam logic [COL_BITS:0] W_CNT = (COL_BITS+1)'(WIDTH);
   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
   logic [1:0]                      r_rst_s;
   logic                            w_rst;
   logic [SYNC_STAGES:0][IW-1:0]    r_sync;
   logic [IW-1:0]                   w_last;
   logic [5:0]                      w_data;
   logic [ROW_BITS-1:0]             w_row;
   logic                            r_clk_rise, r_lat_rise;
   logic [COL_BITS:0]               r_col_cnt, w_cnt_eff;
   logic                            r_line_bad, w_bad_eff, w_room, w_shift;
   logic                            w_good, w_commit, w_swap, w_end;
   logic                            r_wbank, r_rbank;
   logic [1:0]                      r_full, w_free, w_full_n;
   logic [1:0][ROW_BITS-1:0]        r_row_buf;
   logic [COL_BITS-1:0]             w_widx, w_ncol;
   logic [5:0]                      r_mem [2][WIDTH];
   state_t                          r_state;
   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge clk or posedge rst)
      if (rst) r_rst_s <= 2'b11;
      else     r_rst_s <= {r_rst_s[0], 1'b0};
   assign w_rst = r_rst_s[1];
   always_ff @(posedge clk or posedge w_rst)
      if (w_rst) begin
         r_sync     <= '0;
         r_clk_rise <= 1'b0;
         r_lat_rise <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-1:0],
                        {hub_lat, hub_clk, hub_row, hub_r[1], hub_g[1], hub_b[1], hub_r[0], hub_g[0], hub_b[0]}};
         r_clk_rise <= r_sync[SYNC_STAGES-1][CLK_B] & ~r_sync[SYNC_STAGES][CLK_B];
         r_lat_rise <= r_sync[SYNC_STAGES-1][LAT_B] & ~r_sync[SYNC_STAGES][LAT_B];
      end
   // The last stage lines up with the registered edge pulses.
   assign w_last    = r_sync[SYNC_STAGES];
   assign w_data    = w_last[5:0];
   assign w_row     = w_last[ROW_BITS+5:6];
   assign w_room    = r_col_cnt < W_CNT;
   assign w_shift   = r_clk_rise & w_room;
   assign w_cnt_eff = r_col_cnt + {{COL_BITS{1'b0}}, w_shift};
   assign w_bad_eff = r_line_bad | (r_clk_rise & ~w_room);
   assign w_good    = r_lat_rise & (w_cnt_eff == W_CNT) & ~w_bad_eff;
   assign w_commit  = w_good & ~r_full[r_wbank];
   assign w_widx    = COL_BITS'(W_CNT - (COL_BITS+1)'(1) - r_col_cnt);
   assign w_end     = (r_state == SEND) & px_ready & px_last;
   assign w_free    = w_end ? (2'b01 << r_rbank) : 2'b00;
   assign w_full_n  = r_full & ~w_free;
   // A full shift bank is re-aimed at the other bank once it frees, but only between lines.
   assign w_swap    = (w_commit | (r_full[r_wbank] & (r_col_cnt == '0) & ~r_clk_rise)) & ~w_full_n[~r_wbank];
   assign w_ncol    = px_col + COL_BITS'(1);
   always_ff @(posedge clk)
      if (w_shift & ~r_full[r_wbank]) r_mem[r_wbank][w_widx] <= w_data;
   always_ff @(posedge clk or posedge w_rst)
      if (w_rst) begin
         r_col_cnt   <= '0;
         r_line_bad  <= 1'b0;
         r_wbank     <= 1'b0;
         r_full      <= 2'b00;
         r_row_buf   <= '0;
         frame_start <= 1'b0;
         err_len     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         r_col_cnt   <= r_lat_rise ? '0 : w_cnt_eff;
         r_line_bad  <= ~r_lat_rise & w_bad_eff;
         r_full      <= w_full_n | ({1'b0, w_commit} << r_wbank);
         if (w_commit) r_row_buf[r_wbank] <= w_row;
         if (w_swap) r_wbank <= ~r_wbank;
         frame_start <= w_commit & (w_row == '0);
         err_len     <= r_lat_rise & ~w_good;
         overflow    <= w_good & r_full[r_wbank];
      end
   always_ff @(posedge clk or posedge w_rst)
      if (w_rst) begin
         r_state  <= IDLE;
         r_rbank  <= 1'b0;
         px_valid <= 1'b0;
         px_row   <= '0;
         px_col   <= '0;
         px_data  <= '0;
         px_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (r_full[r_rbank]) r_state <= LOAD;
            LOAD: begin
               px_valid <= 1'b1;
               px_col   <= '0;
               px_data  <= r_mem[r_rbank][0];
               px_row   <= r_row_buf[r_rbank];
               px_last  <= 1'b0;
               r_state  <= SEND;
            end
            SEND: if (px_ready) begin
               if (px_last) begin
                  px_valid <= 1'b0;
                  px_last  <= 1'b0;
                  r_rbank  <= ~r_rbank;
                  r_state  <= r_full[~r_rbank] ? LOAD : IDLE;
               end else begin
                  px_col  <= w_ncol;
                  px_data <= r_mem[r_rbank][w_ncol];
                  px_last <= w_ncol == COL_BITS'(WIDTH-1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed bench for hub75_rx with an expected-beat queue.
module tb_hub75_rx;
   logic       clk = 0, rst = 1;
   logic [1:0] hub_r = 0, hub_g = 0, hub_b = 0;
   logic [3:0] hub_row = 0;
   logic       hub_clk = 0, hub_lat = 0, px_ready = 1;
   logic       px_valid, px_last, frame_start, err_len, overflow;
   logic [3:0] px_row;
   logic [4:0] px_col;
   logic [5:0] px_data;
   int n_chk = 0, n_fail = 0, n_beats = 0, n_err = 0, n_ovf = 0, n_fs = 0;
   int b0, e0, o0, f0;
   logic [15:0] q[$];
   hub75_rx dut (
      .clk(clk), .rst(rst), .hub_r(hub_r), .hub_g(hub_g), .hub_b(hub_b), .hub_row(hub_row),
      .hub_clk(hub_clk), .hub_lat(hub_lat), .px_valid(px_valid), .px_ready(px_ready),
      .px_row(px_row), .px_col(px_col), .px_data(px_data), .px_last(px_last),
      .frame_start(frame_start), .err_len(err_len), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (err_len) n_err++;
      if (overflow) n_ovf++;
      if (frame_start) n_fs++;
      if (px_valid && px_ready) begin
         n_beats++;
         if (q.size() == 0) chk("extra_beat", 1, 0);
         else chk("beat", {px_row, px_col, px_data, px_last}, q.pop_front());
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic set_px(input logic [5:0] d);
      hub_r = {d[5], d[2]};
      hub_g = {d[4], d[1]};
      hub_b = {d[3], d[0]};
   endtask
   task automatic shift_n(input int n, input logic [5:0] add, input logic [5:0] xr);
      for (int k = 0; k < n; k++) begin
         set_px(6'(k + int'(add)) ^ xr);
         cyc(2);
         hub_clk = 1;
         cyc(3);
         hub_clk = 0;
         cyc(3);
      end
   endtask
   task automatic latch(input logic [3:0] row);
      hub_row = row;
      cyc(2);
      hub_lat = 1;
      cyc(3);
      hub_lat = 0;
      cyc(3);
   endtask
   task automatic expect_line(input logic [3:0] row, input logic [5:0] add, input logic [5:0] xr);
      for (int c = 0; c < 32; c++) q.push_back({row, 5'(c), 6'(31 - c + int'(add)) ^ xr, c == 31});
   endtask
   task automatic wait_drain();
      for (int i = 0; i < 400 && q.size() > 0; i++) cyc(1);
      chk("drain_left", q.size(), 0);
      cyc(3);
      chk("idle_after", px_valid, 0);
   endtask
   task automatic wait_col(input int c);
      for (int i = 0; i < 300; i++) begin
         if (px_valid && px_col == 5'(c)) break;
         cyc(1);
      end
      chk("reach_col", {px_valid, px_col}, {1'b1, 5'(c)});
   endtask
   initial begin
      cyc(3);
      chk("rst_valid", px_valid, 0);
      chk("rst_pulses", {frame_start, err_len, overflow, px_last}, 0);
      chk("rst_col", px_col, 0);
      rst = 0;
      cyc(5);
      // 1: basic line
      b0 = n_beats; f0 = n_fs;
      expect_line(4'd5, 6'd0, 6'd0);
      shift_n(32, 6'd0, 6'd0);
      latch(4'd5);
      wait_drain();
      chk("t1_beats", n_beats - b0, 32);
      chk("t1_fs", n_fs - f0, 0);
      // 2: backpressure at col 7
      b0 = n_beats;
      expect_line(4'd6, 6'd0, 6'd0);
      shift_n(32, 6'd0, 6'd0);
      latch(4'd6);
      wait_col(7);
      px_ready = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold", {px_valid, px_col, px_data, px_row}, {1'b1, 5'd7, 6'd24, 4'd6});
      end
      cyc(1);
      px_ready = 1;
      wait_drain();
      chk("t2_beats", n_beats - b0, 32);
      // 3: short and long lines
      b0 = n_beats; e0 = n_err;
      shift_n(31, 6'd0, 6'd0);
      latch(4'd2);
      cyc(6);
      chk("t3_err31", n_err - e0, 1);
      shift_n(33, 6'd0, 6'd0);
      latch(4'd2);
      cyc(10);
      chk("t3_err33", n_err - e0, 2);
      chk("t3_nobeat", n_beats - b0, 0);
      // 4: overflow with both banks busy
      px_ready = 0;
      b0 = n_beats; o0 = n_ovf; e0 = n_err;
      expect_line(4'd1, 6'd16, 6'd0);
      expect_line(4'd2, 6'd32, 6'd0);
      shift_n(32, 6'd16, 6'd0); latch(4'd1);
      shift_n(32, 6'd32, 6'd0); latch(4'd2);
      shift_n(32, 6'd48, 6'd0); latch(4'd3);
      cyc(5);
      chk("t4_ovf", n_ovf - o0, 1);
      chk("t4_err", n_err - e0, 0);
      chk("t4_stall", {px_valid, px_col, px_row}, {1'b1, 5'd0, 4'd1});
      chk("t4_nobeat", n_beats - b0, 0);
      px_ready = 1;
      wait_drain();
      chk("t4_beats", n_beats - b0, 64);
      // 5: reset mid-drain
      expect_line(4'd7, 6'd0, 6'h2a);
      shift_n(32, 6'd0, 6'h2a);
      latch(4'd7);
      wait_col(12);
      rst = 1;
      #1;
      chk("t5_rst_valid", px_valid, 0);
      q.delete();
      cyc(3);
      rst = 0;
      cyc(5);
      b0 = n_beats;
      expect_line(4'd9, 6'd3, 6'd0);
      shift_n(32, 6'd3, 6'd0);
      latch(4'd9);
      wait_drain();
      chk("t5_beats", n_beats - b0, 32);
      // 6: last hub_clk rise coincides with latch, row 0
      b0 = n_beats; f0 = n_fs; e0 = n_err;
      expect_line(4'd0, 6'd0, 6'h3f);
      shift_n(31, 6'd0, 6'h3f);
      set_px(6'd32);
      hub_row = 0;
      cyc(2);
      hub_clk = 1; hub_lat = 1;
      cyc(3);
      hub_clk = 0; hub_lat = 0;
      cyc(3);
      wait_drain();
      chk("t6_beats", n_beats - b0, 32);
      chk("t6_fs", n_fs - f0, 1);
      chk("t6_err", n_err - e0, 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
